// File: rtl/turn_controller.sv
// turn_controller: sequences a two-player tic-tac-toe game and owns the 9-cell board
// Ports: clk, reset (synchronous, active-high)
//   p1_req/p1_cell, p2_req/p2_cell : level move requests, cell 0..8 -> pos1..pos9
//   win, clear_req                 : verdict and end-of-game clear from win_detector
//   pos1..pos9                     : board cells (00 empty, 01 P1, 10 P2)
//   p1_ack/p1_nack/p2_ack/p2_nack  : one-cycle request responses
//   timeout                        : one-cycle pulse when a turn is forfeited
//   turn, game_over, result        : player to move, game-over flag, latched outcome
// Optional: define STARTER_ALTERNATE_EN to alternate the starting player on every clear.
module turn_controller #(
    parameter int WIN_LAT = 2,
    parameter int TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p1_req,
    input  logic [3:0] p1_cell,
    input  logic       p2_req,
    input  logic [3:0] p2_cell,
    input  logic [1:0] win,
    input  logic       clear_req,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic       p1_ack,
    output logic       p1_nack,
    output logic       p2_ack,
    output logic       p2_nack,
    output logic       timeout,
    output logic [1:0] turn,
    output logic       game_over,
    output logic [1:0] result
);
    typedef enum logic [1:0] {TURN, CHECK, OVER, CLEAR} state_t;
    state_t      state_q, state_d;
    logic [1:0]  board_q [9];
    logic [1:0]  board_d [9];
    logic        p2_q, p2_d;
    logic [3:0]  move_cnt_q, move_cnt_d;
    logic [2:0]  wait_q, wait_d;
    logic [31:0] idle_q, idle_d;
    logic [1:0]  result_q, result_d;
    logic [1:0]  turn_q, turn_d;
    logic        game_over_q, game_over_d;
    logic        p1_ack_q, p1_ack_d, p1_nack_q, p1_nack_d;
    logic        p2_ack_q, p2_ack_d, p2_nack_q, p2_nack_d;
    logic        timeout_q, timeout_d;
    logic [15:0] occ;
    logic        cur_req;
    logic [3:0]  cur_cell;
`ifdef STARTER_ALTERNATE_EN
    logic        starter_q, starter_d;
`endif

    always_comb begin
        // cells 9..15 read as occupied so out-of-range targets fall into the reject path
        occ = '1;
        for (int i = 0; i < 9; i++) occ[i] = board_q[i] != 2'b00;
        cur_req     = p2_q ? p2_req : p1_req;
        cur_cell    = p2_q ? p2_cell : p1_cell;
        state_d     = state_q;
        board_d     = board_q;
        p2_d        = p2_q;
        move_cnt_d  = move_cnt_q;
        wait_d      = '0;
        idle_d      = '0;
        result_d    = result_q;
        p1_ack_d    = 1'b0;
        p2_ack_d    = 1'b0;
        p1_nack_d   = p1_req;
        p2_nack_d   = p2_req;
        timeout_d   = 1'b0;
`ifdef STARTER_ALTERNATE_EN
        starter_d   = starter_q;
`endif
        unique case (state_q)
            TURN: begin
                if (cur_req && !occ[cur_cell]) begin
                    for (int i = 0; i < 9; i++)
                        if (cur_cell == 4'(i)) board_d[i] = p2_q ? 2'b10 : 2'b01;
                    move_cnt_d = move_cnt_q + 4'd1;
                    state_d    = CHECK;
                    p1_ack_d   = !p2_q;
                    p2_ack_d   = p2_q;
                    p1_nack_d  = p1_req && p2_q;
                    p2_nack_d  = p2_req && !p2_q;
                end else if (TIMEOUT != 0 && idle_q == 32'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    p2_d      = !p2_q;
                end else begin
                    idle_d = idle_q + 32'd1;
                end
            end
            CHECK: begin
                if (wait_q == 3'(WIN_LAT - 1)) begin
                    if (win != 2'b00) begin
                        result_d = win;
                        state_d  = OVER;
                    end else if (move_cnt_q == 4'd9) begin
                        result_d = 2'b11;
                        state_d  = OVER;
                    end else begin
                        p2_d    = !p2_q;
                        state_d = TURN;
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            OVER: begin
                if (clear_req) begin
                    state_d    = CLEAR;
                    board_d    = '{default: 2'b00};
                    move_cnt_d = '0;
                    result_d   = 2'b00;
                end
            end
            CLEAR: begin
                state_d = TURN;
`ifdef STARTER_ALTERNATE_EN
                starter_d = !starter_q;
                p2_d      = !starter_q;
`else
                p2_d      = 1'b0;
`endif
            end
        endcase
        turn_d      = (state_d == TURN) ? (p2_d ? 2'b10 : 2'b01) : 2'b00;
        game_over_d = state_d == OVER;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= TURN;
            board_q     <= '{default: 2'b00};
            p2_q        <= 1'b0;
            move_cnt_q  <= '0;
            wait_q      <= '0;
            idle_q      <= '0;
            result_q    <= 2'b00;
            turn_q      <= 2'b01;
            game_over_q <= 1'b0;
            p1_ack_q    <= 1'b0;
            p1_nack_q   <= 1'b0;
            p2_ack_q    <= 1'b0;
            p2_nack_q   <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef STARTER_ALTERNATE_EN
            starter_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            p2_q        <= p2_d;
            move_cnt_q  <= move_cnt_d;
            wait_q      <= wait_d;
            idle_q      <= idle_d;
            result_q    <= result_d;
            turn_q      <= turn_d;
            game_over_q <= game_over_d;
            p1_ack_q    <= p1_ack_d;
            p1_nack_q   <= p1_nack_d;
            p2_ack_q    <= p2_ack_d;
            p2_nack_q   <= p2_nack_d;
            timeout_q   <= timeout_d;
`ifdef STARTER_ALTERNATE_EN
            starter_q   <= starter_d;
`endif
        end
    end

    assign pos1      = board_q[0];
    assign pos2      = board_q[1];
    assign pos3      = board_q[2];
    assign pos4      = board_q[3];
    assign pos5      = board_q[4];
    assign pos6      = board_q[5];
    assign pos7      = board_q[6];
    assign pos8      = board_q[7];
    assign pos9      = board_q[8];
    assign p1_ack    = p1_ack_q;
    assign p1_nack   = p1_nack_q;
    assign p2_ack    = p2_ack_q;
    assign p2_nack   = p2_nack_q;
    assign timeout   = timeout_q;
    assign turn      = turn_q;
    assign game_over = game_over_q;
    assign result    = result_q;
endmodule

// File: doc/turn_controller.md
Name: turn_controller

Overview:
- Sequences a two-player tic-tac-toe game and owns the 9-cell board register.
- Arbitrates move requests from player 1 and player 2. Only the player whose turn it is may write; an illegal move is rejected.
- Waits for win_detector to evaluate each move, then toggles the turn or ends the game.
- Drives pos1..pos9 into win_detector. Consumes win_detector's win and reset outputs.

Parameters:
- WIN_LAT, 2: cycles between a board write and the cycle in which win is sampled. Range 1..7.
- TIMEOUT, 0: idle cycles in TURN before the turn is forfeited. 0 disables the timeout. Counter is 32 bits wide.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- p1_req  in  1  player 1 move request, level, sampled every cycle
- p1_cell  in  4  player 1 target cell, 0..8 maps to pos1..pos9
- p2_req  in  1  player 2 move request
- p2_cell  in  4  player 2 target cell
- win  in  2  from win_detector: 00 playing, 01 P1 win, 10 P2 win, 11 tie
- clear_req  in  1  end-of-game clear, driven by win_detector reset output
- pos1..pos9  out  2 each  board cells: 00 empty, 01 P1, 10 P2
- p1_ack, p1_nack, p2_ack, p2_nack  out  1 each  one-cycle pulses
- timeout  out  1  one-cycle pulse when a turn is forfeited
- turn  out  2  01 P1 to move, 10 P2 to move, 00 no move allowed
- game_over  out  1  high while in OVER
- result  out  2  latched outcome, same encoding as win

Behaviour:
- Reset values:
  - All pos = 00; turn = 01; game_over = 0; result = 00.
  - All ack/nack/timeout pulses = 0.
  - move_cnt = 0; state = TURN; starter = P1.
- Reset mid-game wins over every other event. Board clears on the next edge.
- States: TURN, CHECK, OVER, CLEAR.
- TURN, let cur be the player whose turn it is:
  - cur_req with cell <= 8 and that cell = 00:
    - Write the cur code to the cell. Pulse cur_ack next cycle.
    - move_cnt += 1. Go to CHECK. turn = 00 while in CHECK.
  - cur_req with cell > 8 or cell occupied: pulse cur_nack. Board unchanged. Stay in TURN.
  - Non-current player's req: pulse that player's nack, even if cur_req is high in the same cycle.
  - Both req same cycle: cur is processed; the other player is nacked.
  - A request held high is re-evaluated every cycle. A legal held request is acked exactly once, because the state leaves TURN.
  - Timeout (TIMEOUT != 0):
    - Idle counter clears on state entry and on any ack.
    - When it reaches TIMEOUT-1 with no cur ack that cycle: pulse timeout, toggle turn, clear the counter. Board unchanged.
- CHECK:
  - Wait counter runs WIN_LAT cycles. Requests are nacked.
  - Final cycle, if win != 00: result = win, go to OVER.
  - Final cycle, else if move_cnt = 9: result = 11, go to OVER. This is a tie guard.
  - Otherwise toggle the current player and return to TURN.
- OVER:
  - game_over = 1; turn = 00; board and result held; all requests nacked.
  - clear_req = 1: go to CLEAR.
- CLEAR, one cycle:
  - All pos = 00; move_cnt = 0; result = 00; game_over = 0.
  - Next state TURN, with turn = starter.
- clear_req outside OVER is ignored.
- Ack/nack/timeout are registered: each asserts for exactly the one cycle after the decision edge.

Optional Feature:
- Macro: STARTER_ALTERNATE_EN
- Defined: starter toggles on every CLEAR, so games alternate between P1 and P2 starting. Reset restores starter = P1.
- Undefined: P1 always starts. The starter register is removed.

Test Plan:
- Reset, then P1 cell 0, P2 cell 3, P1 cell 1, P2 cell 4, P1 cell 2; model drives win = 01 two cycles after the last write.
  - Expect 5 acks, pos1..3 = 01, pos4..5 = 10.
  - Expect game_over = 1 and result = 01 after CHECK.
- TURN with P1 to move; P1 targets an occupied cell, then cell 9 → two p1_nack pulses, board unchanged, turn stays 01.
- P1 and P2 request in the same cycle, P2 to move → p2_ack and p1_nack in the same cycle; P2 cell written.
- Full board with no line, win held 00 → after move 9 and WIN_LAT cycles: result = 11, game_over = 1.
- TIMEOUT = 20, P1 idle → timeout pulse at idle cycle 20, turn = 10; then a P2 move is acked.
- In OVER, pulse clear_req → next cycle CLEAR: board 00, then TURN with turn = 01 (10 for the second game if STARTER_ALTERNATE_EN). Assert reset mid-CHECK → board cleared next edge, turn = 01.
